// File: rtl/slv_fsm_pkg.sv
// Shared state encoding and default parameters for the slave-select FSM mux.
package slv_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH  = 64;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_SLV_NUM     = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/slv_fsm_timer.sv
// Saturating access timer; expired flags the edge on which the count reaches TIMEOUT_CYC-1.
module slv_fsm_timer
    import slv_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    // Count waiting cycles; clear wins over enable, saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expire when this cycle's increment lands on TIMEOUT_CYC-1; zero disables.
    always_comb begin
        expired = 1'b0;
        if ((TIMEOUT_CYC != 0) && en) begin
            expired = (cnt_inc >= (CNT_W+1)'(TIMEOUT_CYC - 1));
        end
    end

endmodule

// File: rtl/slv_fsm_mux.sv
// Single-outstanding master-to-slave access FSM with one-hot slave select and timeout.
module slv_fsm_mux
    import slv_fsm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned SLV_NUM     = DEF_SLV_NUM,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mst__fsm__req_vld,
    output logic                          fsm__mst__req_rdy,
    input  logic                          mst__fsm__rd_en,
    input  logic                          mst__fsm__wr_en,
    input  logic [ADDR_WIDTH-1:0]         mst__fsm__addr,
    input  logic [DATA_WIDTH-1:0]         mst__fsm__wr_data,
    input  logic [SLV_NUM-1:0]            mst__fsm__sel,
    input  logic                          mst__fsm__sync_reset,
    output logic                          fsm__mst__ack_vld,
    input  logic                          mst__fsm__ack_rdy,
    output logic [DATA_WIDTH-1:0]         fsm__mst__rd_data,
    output logic                          fsm__mst__err,
    output logic [SLV_NUM-1:0]            fsm__slv__req_vld,
    input  logic [SLV_NUM-1:0]            slv__fsm__req_rdy,
    output logic [SLV_NUM-1:0]            fsm__slv__ack_rdy,
    input  logic [SLV_NUM-1:0]            slv__fsm__ack_vld,
    input  logic [SLV_NUM*DATA_WIDTH-1:0] slv__fsm__rd_data,
    output logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
    output logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
    output logic                          fsm__slv__wr_en,
    output logic                          fsm__slv__rd_en,
    output logic                          fsm__slv__sync_reset
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rd_en_q;
    logic                  wr_en_q;
    logic [SLV_NUM-1:0]    sel_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_nxt;
    logic                  err_q;
    logic                  err_nxt;
    logic                  resp_load;
    logic [DATA_WIDTH-1:0] slv_rd_mux;
    logic                  accept;
    logic                  sel_onehot;
    logic                  bad_cmd;
    logic                  busy;
    logic                  ack_hit;
    logic                  rdy_hit;
    logic                  timeout;

    assign accept     = mst__fsm__req_vld && fsm__mst__req_rdy;
    assign sel_onehot = (mst__fsm__sel != '0) &&
                        ((mst__fsm__sel & (mst__fsm__sel - SLV_NUM'(1))) == '0);
    assign bad_cmd    = !sel_onehot || (mst__fsm__rd_en == mst__fsm__wr_en);
    assign busy       = (state == WAIT_RDY) || (state == WAIT_ACK);
    assign ack_hit    = |(slv__fsm__ack_vld & sel_q);
    assign rdy_hit    = |(slv__fsm__req_rdy & sel_q);

    slv_fsm_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept || mst__fsm__sync_reset),
        .en      (busy),
        .expired (timeout)
    );

    // Select the latched slave's read data.
    always_comb begin
        slv_rd_mux = '0;
        for (int i = 0; i < int'(SLV_NUM); i++) begin
            if (sel_q[i]) begin
                slv_rd_mux = slv_rd_mux | slv__fsm__rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and response capture; ack beats timeout, sync_reset beats everything.
    always_comb begin
        state_nxt   = state;
        resp_load   = 1'b0;
        rd_data_nxt = '0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    resp_load = bad_cmd;
                    err_nxt   = 1'b1;
                    state_nxt = bad_cmd ? RESP : WAIT_RDY;
                end
            end
            WAIT_RDY, WAIT_ACK: begin
                if (ack_hit) begin
                    resp_load   = 1'b1;
                    rd_data_nxt = wr_en_q ? '0 : slv_rd_mux;
                    state_nxt   = RESP;
                end else if (timeout) begin
                    resp_load = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else if ((state == WAIT_RDY) && rdy_hit) begin
                    state_nxt = WAIT_ACK;
                end
            end
            RESP: begin
                if (mst__fsm__ack_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (mst__fsm__sync_reset) begin
            state_nxt = IDLE;
            resp_load = 1'b0;
        end
    end

    // Command latch on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            sel_q     <= '0;
        end else if (accept) begin
            addr_q    <= mst__fsm__addr;
            wr_data_q <= mst__fsm__wr_data;
            rd_en_q   <= mst__fsm__rd_en;
            wr_en_q   <= mst__fsm__wr_en;
            sel_q     <= mst__fsm__sel;
        end
    end

    // Response hold registers, stable through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else if (resp_load) begin
            rd_data_q <= rd_data_nxt;
            err_q     <= err_nxt;
        end
    end

    assign fsm__mst__req_rdy    = (state == IDLE) && !mst__fsm__sync_reset;
    assign fsm__mst__ack_vld    = (state == RESP);
    assign fsm__mst__rd_data    = (state == RESP) ? rd_data_q : '0;
    assign fsm__mst__err        = (state == RESP) && err_q;
    assign fsm__slv__req_vld    = (state == WAIT_RDY) ? sel_q : '0;
    assign fsm__slv__ack_rdy    = (state == WAIT_ACK) ? sel_q : '0;
    assign fsm__slv__addr       = busy ? addr_q : '0;
    assign fsm__slv__wr_data    = busy ? wr_data_q : '0;
    assign fsm__slv__wr_en      = busy && wr_en_q;
    assign fsm__slv__rd_en      = busy && rd_en_q;
    assign fsm__slv__sync_reset = mst__fsm__sync_reset;

endmodule

// File: tb/tb_slv_fsm_mux.sv
// Directed bench for slv_fsm_mux: slave responder model plus response scoreboard.
module tb_slv_fsm_mux;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned SN = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              req_vld = 1'b0;
    logic              t8_req_vld = 1'b0;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [SN-1:0]     sel = '0;
    logic              sync_reset = 1'b0;
    logic              mst_ack_rdy = 1'b1;
    logic [SN-1:0]     slv_req_rdy = '0;
    logic [SN-1:0]     slv_ack_vld = '0;
    logic [SN*DW-1:0]  slv_rd_data = '0;

    logic              req_rdy, ack_vld, err, s_wr_en, s_rd_en, s_sync;
    logic [DW-1:0]     rd_data, s_wr_data;
    logic [SN-1:0]     s_req_vld, s_ack_rdy;
    logic [AW-1:0]     s_addr;
    logic              t8_req_rdy, t8_ack_vld, t8_err, t8_wr_en, t8_rd_en, t8_sync;
    logic [DW-1:0]     t8_rd_data, t8_wr_data;
    logic [SN-1:0]     t8_s_req_vld, t8_s_ack_rdy;
    logic [AW-1:0]     t8_addr;

    slv_fsm_mux dut (
        .clk(clk), .rst(rst),
        .mst__fsm__req_vld(req_vld), .fsm__mst__req_rdy(req_rdy),
        .mst__fsm__rd_en(rd_en), .mst__fsm__wr_en(wr_en),
        .mst__fsm__addr(addr), .mst__fsm__wr_data(wr_data), .mst__fsm__sel(sel),
        .mst__fsm__sync_reset(sync_reset),
        .fsm__mst__ack_vld(ack_vld), .mst__fsm__ack_rdy(mst_ack_rdy),
        .fsm__mst__rd_data(rd_data), .fsm__mst__err(err),
        .fsm__slv__req_vld(s_req_vld), .slv__fsm__req_rdy(slv_req_rdy),
        .fsm__slv__ack_rdy(s_ack_rdy), .slv__fsm__ack_vld(slv_ack_vld),
        .slv__fsm__rd_data(slv_rd_data),
        .fsm__slv__addr(s_addr), .fsm__slv__wr_data(s_wr_data),
        .fsm__slv__wr_en(s_wr_en), .fsm__slv__rd_en(s_rd_en),
        .fsm__slv__sync_reset(s_sync)
    );

    slv_fsm_mux #(.TIMEOUT_CYC(8)) dut_t8 (
        .clk(clk), .rst(rst),
        .mst__fsm__req_vld(t8_req_vld), .fsm__mst__req_rdy(t8_req_rdy),
        .mst__fsm__rd_en(rd_en), .mst__fsm__wr_en(wr_en),
        .mst__fsm__addr(addr), .mst__fsm__wr_data(wr_data), .mst__fsm__sel(sel),
        .mst__fsm__sync_reset(sync_reset),
        .fsm__mst__ack_vld(t8_ack_vld), .mst__fsm__ack_rdy(mst_ack_rdy),
        .fsm__mst__rd_data(t8_rd_data), .fsm__mst__err(t8_err),
        .fsm__slv__req_vld(t8_s_req_vld), .slv__fsm__req_rdy(slv_req_rdy),
        .fsm__slv__ack_rdy(t8_s_ack_rdy), .slv__fsm__ack_vld(slv_ack_vld),
        .slv__fsm__rd_data(slv_rd_data),
        .fsm__slv__addr(t8_addr), .fsm__slv__wr_data(t8_wr_data),
        .fsm__slv__wr_en(t8_wr_en), .fsm__slv__rd_en(t8_rd_en),
        .fsm__slv__sync_reset(t8_sync)
    );

    // Observed master side of whichever instance is under test.
    logic          use_t8 = 1'b0;
    logic          o_req_rdy, o_ack_vld, o_err, o_accept;
    logic [DW-1:0] o_rd_data;
    assign o_req_rdy = use_t8 ? t8_req_rdy : req_rdy;
    assign o_ack_vld = use_t8 ? t8_ack_vld : ack_vld;
    assign o_err     = use_t8 ? t8_err     : err;
    assign o_rd_data = use_t8 ? t8_rd_data : rd_data;
    assign o_accept  = use_t8 ? (t8_req_vld && t8_req_rdy) : (req_vld && req_rdy);

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Slave responder: ready after rdy_dly request cycles, ack after ack_dly ack-ready cycles.
    int   rdy_dly[SN] = '{default: 0};
    int   ack_dly[SN] = '{default: 0};
    int   rcnt[SN]    = '{default: 0};
    int   acnt[SN]    = '{default: 0};
    int   req_len[SN] = '{default: 0};
    logic stray3      = 1'b0;
    logic any_req     = 1'b0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < int'(SN); i++) begin
            if (s_req_vld[i]) begin
                slv_req_rdy[i] = (rcnt[i] >= rdy_dly[i]);
                rcnt[i]++;
                req_len[i] = rcnt[i];
                any_req = 1'b1;
            end else begin
                slv_req_rdy[i] = 1'b0;
                rcnt[i] = 0;
            end
            if (s_ack_rdy[i]) begin
                slv_ack_vld[i] = (acnt[i] >= ack_dly[i]);
                acnt[i]++;
            end else begin
                slv_ack_vld[i] = 1'b0;
                acnt[i] = 0;
            end
        end
        if (stray3) slv_ack_vld[3] = 1'b1;
    end

    // Scoreboard: latency from accept, response value every RESP cycle, pop on handshake.
    exp_t exp_q[$];
    int   lat = 0;
    bit   tracking = 1'b0;
    bit   seen = 1'b0;

    always @(negedge clk) begin
        if (tracking) begin
            lat++;
            if (o_ack_vld && !seen && exp_q.size() != 0) begin
                seen = 1'b1;
                check("resp_latency", 64'(lat), 64'(exp_q[0].lat));
            end
        end
        if (o_ack_vld && exp_q.size() == 0) begin
            check("unexpected_ack_vld", 64'(o_ack_vld), 64'd0);
        end else if (o_ack_vld) begin
            check("resp_rd_data", 64'(o_rd_data), 64'(exp_q[0].data));
            check("resp_err", 64'(o_err), 64'(exp_q[0].err));
            if (mst_ack_rdy) begin
                void'(exp_q.pop_front());
                tracking = 1'b0;
            end
        end
        if (o_accept) begin
            tracking = 1'b1;
            lat = 0;
            seen = 1'b0;
        end
        if (sync_reset) tracking = 1'b0;
    end

    task automatic push_exp(input logic [DW-1:0] d, input logic e, input int l);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.lat  = l;
        exp_q.push_back(x);
    endtask

    task automatic do_req(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SN-1:0] s, input bit t8);
        bit ok;
        @(posedge clk); #1;
        rd_en = r; wr_en = w; addr = a; wr_data = d; sel = s;
        if (t8) t8_req_vld = 1'b1; else req_vld = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (o_req_rdy) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_vld = 1'b0;
        t8_req_vld = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        slv_rd_data[0*DW +: DW] = 32'h0BAD_F00D;
        slv_rd_data[1*DW +: DW] = 32'h1234_5678;
        slv_rd_data[2*DW +: DW] = 32'hA5A5_0001;
        slv_rd_data[3*DW +: DW] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_rdy", 64'(req_rdy), 64'd1);
        check("rst_ack_vld", 64'(ack_vld), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_slv_req_vld", 64'(s_req_vld), 64'd0);
        check("rst_slv_ack_rdy", 64'(s_ack_rdy), 64'd0);
        check("rst_slv_addr", s_addr, 64'd0);
        check("rst_slv_cmd", {29'd0, s_wr_en, s_rd_en, s_sync, s_wr_data}, 64'd0);

        // Read from slave 2: ready at once, ack in its third ack-ready cycle.
        rdy_dly[2] = 0; ack_dly[2] = 2;
        push_exp(32'hA5A5_0001, 1'b0, 5);
        do_req(1'b1, 1'b0, 64'h1000_0000_0000_0040, 32'h0, 4'b0100, 1'b0);
        @(negedge clk);
        check("rd_slv_req_vld", 64'(s_req_vld), 64'b0100);
        check("rd_slv_addr", s_addr, 64'h1000_0000_0000_0040);
        check("rd_slv_rd_en", 64'({s_rd_en, s_wr_en}), 64'b10);
        check("rd_slv_ack_rdy", 64'(s_ack_rdy), 64'd0);
        wait_drain();
        @(negedge clk);
        check("idle_slv_addr", s_addr, 64'd0);
        check("idle_req_rdy", 64'(req_rdy), 64'd1);

        // Write to slave 0 held off for 10 cycles.
        rdy_dly[0] = 10; ack_dly[0] = 0;
        push_exp(32'h0, 1'b0, 13);
        do_req(1'b0, 1'b1, 64'h20, 32'hCAFE_0002, 4'b0001, 1'b0);
        @(negedge clk);
        check("wr_slv_wr_data", 64'(s_wr_data), 64'hCAFE_0002);
        check("wr_slv_wr_en", 64'({s_rd_en, s_wr_en}), 64'b01);
        wait_drain();
        check("wr_req_vld_cycles", 64'(req_len[0]), 64'd11);

        // Illegal commands answer with an error one cycle after accept.
        any_req = 1'b0;
        push_exp(32'h0, 1'b1, 1);
        do_req(1'b1, 1'b0, 64'h30, 32'h0, 4'b0110, 1'b0);
        wait_drain();
        push_exp(32'h0, 1'b1, 1);
        do_req(1'b1, 1'b0, 64'h34, 32'h0, 4'b0000, 1'b0);
        wait_drain();
        push_exp(32'h0, 1'b1, 1);
        do_req(1'b1, 1'b1, 64'h38, 32'h0, 4'b0001, 1'b0);
        wait_drain();
        check("bad_cmd_no_slv_req", 64'(any_req), 64'd0);

        // Stalled response with stray acks from unselected slave 3.
        rdy_dly[1] = 0; ack_dly[1] = 3;
        stray3 = 1'b1;
        mst_ack_rdy = 1'b0;
        push_exp(32'h1234_5678, 1'b0, 6);
        do_req(1'b1, 1'b0, 64'h40, 32'h0, 4'b0010, 1'b0);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (ack_vld) got = 1'b1;
            end
            if (!got) check("stall_resp_timeout", 64'd0, 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ack_vld", 64'(ack_vld), 64'd1);
            check("stall_slv_ack_rdy", 64'(s_ack_rdy), 64'd0);
        end
        @(posedge clk); #1;
        mst_ack_rdy = 1'b1;
        wait_drain();
        stray3 = 1'b0;

        // sync_reset while waiting for an ack discards the access.
        ack_dly[2] = 100;
        do_req(1'b1, 1'b0, 64'h50, 32'h0, 4'b0100, 1'b0);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (s_ack_rdy[2]) got = 1'b1;
            end
            check("sr_reached_wait_ack", 64'(got), 64'd1);
        end
        @(posedge clk); #1;
        sync_reset = 1'b1;
        @(negedge clk);
        check("sr_slv_sync_reset", 64'(s_sync), 64'd1);
        check("sr_req_rdy_low", 64'(req_rdy), 64'd0);
        @(posedge clk); #1;
        sync_reset = 1'b0;
        @(negedge clk);
        check("sr_req_rdy", 64'(req_rdy), 64'd1);
        check("sr_slv_ack_rdy", 64'(s_ack_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("sr_no_ack_vld", 64'(ack_vld), 64'd0);
            @(negedge clk);
        end
        ack_dly[2] = 0;

        // Timeout on the TIMEOUT_CYC=8 instance with no slave reply.
        use_t8 = 1'b1;
        push_exp(32'h0, 1'b1, 8);
        do_req(1'b1, 1'b0, 64'h60, 32'h0, 4'b0001, 1'b1);
        @(negedge clk);
        check("t8_slv_req_vld", 64'(t8_s_req_vld), 64'b0001);
        wait_drain();
        use_t8 = 1'b0;

        // Back-to-back reads to slave 2.
        push_exp(32'hA5A5_0001, 1'b0, 3);
        push_exp(32'hA5A5_0001, 1'b0, 3);
        do_req(1'b1, 1'b0, 64'h70, 32'h0, 4'b0100, 1'b0);
        do_req(1'b1, 1'b0, 64'h74, 32'h0, 4'b0100, 1'b0);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
